// File: rtl/nco_scale_pkg.sv
// rtl/nco_scale_pkg.sv - shared types, constants and clamp helpers for nco_scale
// Purpose: common definitions imported by nco_scale and gain_ramp.
// Ports: none (package).
package nco_scale_pkg;

  localparam int          GAIN_FRAC = 14;
  localparam logic [15:0] GAIN_ONE  = 16'h4000;

  // Post-shift sum width: 19 bits hold the scaled product plus offset, one spare.
  localparam int WIDE_W = 20;

  typedef logic signed [15:0]       sample_t;
  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_t;

  localparam wide_t SAMPLE_MAX = 20'sd32767;
  localparam wide_t SAMPLE_MIN = -20'sd32768;

  function automatic sample_t sat16(input wide_t x);
    if (x > SAMPLE_MAX) begin
      return 16'sh7fff;
    end else if (x < SAMPLE_MIN) begin
      return 16'sh8000;
    end else begin
      return sample_t'(x);
    end
  endfunction

  function automatic logic clips16(input wide_t x);
    return (x > SAMPLE_MAX) || (x < SAMPLE_MIN);
  endfunction

endpackage

// File: rtl/nco_scale_gain_ramp.sv
// rtl/nco_scale_gain_ramp.sv - per-channel glitch-free gain ramp (IDLE/RAMP FSM)
// Purpose: holds current and target gain of one channel and walks the current
//          gain toward the target by at most RAMP_STEP on each shared tick.
// Ports:
//   clk_i     clock
//   rst_ni    asynchronous active-low reset (gain returns to GAIN_RST)
//   tick_i    shared ramp prescaler tick
//   load_i    accepted config for this channel (only issued while idle)
//   target_i  new target gain, unsigned Q2.14
//   gain_o    current gain
//   busy_o    ramp in progress
module gain_ramp
  import nco_scale_pkg::*;
#(
  parameter logic [15:0] GAIN_RST  = GAIN_ONE,
  parameter int          RAMP_STEP = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        tick_i,
  input  logic        load_i,
  input  logic [15:0] target_i,
  output logic [15:0] gain_o,
  output logic        busy_o
);

  localparam logic [15:0] STEP16 = 16'(RAMP_STEP);

  ramp_state_t state_q, state_d;
  logic [15:0] cur_q, cur_d;
  logic [15:0] tgt_q, tgt_d;
  logic [15:0] diff;
  logic [15:0] step;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cur_q   <= GAIN_RST;
      tgt_q   <= GAIN_RST;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    // Unsigned distance; the last step is trimmed so the ramp never overshoots.
    diff = (tgt_q >= cur_q) ? (tgt_q - cur_q) : (cur_q - tgt_q);
    step = (32'(diff) > RAMP_STEP) ? STEP16 : diff;
    case (state_q)
      IDLE: begin
        if (load_i) begin
          tgt_d = target_i;
          if (target_i != cur_q) begin
            state_d = RAMP;
          end
        end
      end
      RAMP: begin
        if (tick_i) begin
          cur_d = (tgt_q > cur_q) ? (cur_q + step) : (cur_q - step);
          if (cur_d == tgt_q) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gain_o = cur_q;
  assign busy_o = (state_q == RAMP);

endmodule

// File: rtl/nco_scale.sv
// rtl/nco_scale.sv - two-channel gain/offset scaler with rounding, saturation and gain ramp
// Purpose: scales even/odd sample pairs of two channels by a Q2.14 gain plus a
//          signed offset over a fixed 3-stage pipeline; gain changes are ramped.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   din1..din4               ch1 even/odd, ch2 even/odd samples (signed)
//   cfg_valid/cfg_ready      config handshake; ready only while both channels idle
//   cfg_ch/cfg_gain/cfg_offset  channel select, target gain, offset
//   dout1..dout4             scaled samples, same mapping as din1..din4
//   ramp_busy[1:0]           per-channel ramp in progress
//   sat[1:0], sat_clr        sticky per-channel saturation flag and its clear
module nco_scale
  import nco_scale_pkg::*;
#(
  parameter logic [15:0] GAIN_RST  = 16'h4000,
  parameter int          RAMP_STEP = 64,
  parameter int          RAMP_DIV  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] din1,
  input  logic signed [15:0] din2,
  input  logic signed [15:0] din3,
  input  logic signed [15:0] din4,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic               cfg_ch,
  input  logic        [15:0] cfg_gain,
  input  logic signed [15:0] cfg_offset,
  output logic signed [15:0] dout1,
  output logic signed [15:0] dout2,
  output logic signed [15:0] dout3,
  output logic signed [15:0] dout4,
  output logic         [1:0] ramp_busy,
  output logic         [1:0] sat,
  input  logic               sat_clr
);

  localparam int            PW       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(RAMP_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;
  logic          rdy_q;
  logic          accept;
  logic [15:0]   gain_cur [2];
  sample_t       off_q    [2];

  sample_t              s1_din_q  [4];
  logic [15:0]          s1_gain_q [2];
  sample_t              s1_off_q  [2];
  logic signed [32:0]   s2_prod_q [4];
  sample_t              s2_off_q  [2];
  sample_t              dout_q    [4];
  sample_t              dout_d    [4];
  logic signed [33:0]   rnd       [4];
  wide_t                scaled    [4];
  logic [1:0]           sat_q, sat_d;

  // rdy_q holds cfg_ready low through reset and for the first clock after it.
  assign cfg_ready = rdy_q & ~(ramp_busy[0] | ramp_busy[1]);
  assign accept    = cfg_valid & cfg_ready;
  assign tick      = (pre_q == PRE_LAST);

  // Restart on accept so the first ramp step lands exactly RAMP_DIV clocks later.
  always_comb begin
    pre_d = pre_q + PW'(1);
    if (accept || tick) begin
      pre_d = '0;
    end
  end

  for (genvar c = 0; c < 2; c++) begin : g_ramp
    gain_ramp #(
      .GAIN_RST (GAIN_RST),
      .RAMP_STEP(RAMP_STEP)
    ) u_ramp (
      .clk_i   (clk),
      .rst_ni  (rst),
      .tick_i  (tick),
      .load_i  (accept && (cfg_ch == 1'(c))),
      .target_i(cfg_gain),
      .gain_o  (gain_cur[c]),
      .busy_o  (ramp_busy[c])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q <= '0;
      rdy_q <= 1'b0;
      sat_q <= 2'b00;
      for (int c = 0; c < 2; c++) begin
        off_q[c]     <= '0;
        s1_gain_q[c] <= '0;
        s1_off_q[c]  <= '0;
        s2_off_q[c]  <= '0;
      end
      for (int i = 0; i < 4; i++) begin
        s1_din_q[i]  <= '0;
        s2_prod_q[i] <= '0;
        dout_q[i]    <= '0;
      end
    end else begin
      pre_q <= pre_d;
      rdy_q <= 1'b1;
      sat_q <= sat_d;
      if (accept) begin
        off_q[cfg_ch] <= cfg_offset;
      end
      // S1: samples plus a per-channel gain/offset snapshot shared by both samples.
      s1_din_q[0] <= din1;
      s1_din_q[1] <= din2;
      s1_din_q[2] <= din3;
      s1_din_q[3] <= din4;
      for (int c = 0; c < 2; c++) begin
        s1_gain_q[c] <= gain_cur[c];
        s1_off_q[c]  <= off_q[c];
        s2_off_q[c]  <= s1_off_q[c];
      end
      // S2: signed sample times zero-extended unsigned gain.
      for (int i = 0; i < 4; i++) begin
        s2_prod_q[i] <= 33'(s1_din_q[i]) * 33'($signed({1'b0, s1_gain_q[i/2]}));
        dout_q[i]    <= dout_d[i];
      end
    end
  end

  // S3: round half-up, drop the fraction, add offset, clamp.
  always_comb begin
    sat_d = sat_clr ? 2'b00 : sat_q;
    for (int i = 0; i < 4; i++) begin
      rnd[i]    = 34'(s2_prod_q[i]) + 34'sd8192;
      scaled[i] = wide_t'(rnd[i] >>> GAIN_FRAC) + wide_t'(s2_off_q[i/2]);
      dout_d[i] = sat16(scaled[i]);
      // Set dominates clear when a clamp coincides with sat_clr.
      if (clips16(scaled[i])) begin
        sat_d[i/2] = 1'b1;
      end
    end
  end

  assign dout1 = dout_q[0];
  assign dout2 = dout_q[1];
  assign dout3 = dout_q[2];
  assign dout4 = dout_q[3];
  assign sat   = sat_q;

endmodule

// File: tb/tb_nco_scale.sv
// tb/tb_nco_scale.sv - scoreboard bench for nco_scale
module tb_nco_scale;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic signed [15:0] din1, din2, din3, din4;
  logic               cfg_valid, cfg_ready, cfg_ch, sat_clr;
  logic        [15:0] cfg_gain;
  logic signed [15:0] cfg_offset;
  logic signed [15:0] dout1, dout2, dout3, dout4;
  logic         [1:0] ramp_busy, sat;

  nco_scale dut (
    .clk(clk), .rst(rst),
    .din1(din1), .din2(din2), .din3(din3), .din4(din4),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_gain(cfg_gain), .cfg_offset(cfg_offset),
    .dout1(dout1), .dout2(dout2), .dout3(dout3), .dout4(dout4),
    .ramp_busy(ramp_busy), .sat(sat), .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit en;
    int e[4];
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   mdl_gain[2];
  int   mdl_off[2];

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Reference: floor((d*g + 8192) / 16384) + offset, clamped to 16 bits.
  function automatic int ref_scale(input int d, input int g, input int o);
    longint p, q, r;
    p = longint'(d) * longint'(g) + 64'sd8192;
    if (p >= 0) q = p / 16384;
    else        q = -((-p + 16383) / 16384);
    r = q + o;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  task automatic step(input bit en);
    exp_t it;
    it.en   = en;
    it.e[0] = ref_scale(int'(din1), mdl_gain[0], mdl_off[0]);
    it.e[1] = ref_scale(int'(din2), mdl_gain[0], mdl_off[0]);
    it.e[2] = ref_scale(int'(din3), mdl_gain[1], mdl_off[1]);
    it.e[3] = ref_scale(int'(din4), mdl_gain[1], mdl_off[1]);
    sbq.push_back(it);
    @(posedge clk);
    @(negedge clk);
    if (sbq.size() == 3) begin
      it = sbq.pop_front();
      if (it.en) begin
        check("dout1", dout1, it.e[0]);
        check("dout2", dout2, it.e[1]);
        check("dout3", dout3, it.e[2]);
        check("dout4", dout4, it.e[3]);
      end
    end
  endtask

  task automatic do_cfg(input bit ch, input int g, input int o);
    bit ok;
    ok         = 1'b0;
    cfg_valid  = 1'b1;
    cfg_ch     = ch;
    cfg_gain   = 16'(g);
    cfg_offset = 16'(o);
    for (int i = 0; i < 5000 && !ok; i++) begin
      ok = cfg_ready;
      step(1'b1);
    end
    cfg_valid = 1'b0;
    check("cfg_accept", ok, 1);
    if (ok) mdl_off[ch] = o;
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc && ramp_busy != 2'b00; i++) step(1'b0);
    check("ramp_done", ramp_busy, 0);
  endtask

  task automatic flush();
    din1 = 0; din2 = 0; din3 = 0; din4 = 0;
    repeat (3) step(1'b1);
  endtask

  task automatic rand_pairs(input int n);
    for (int i = 0; i < n; i++) begin
      din1 = 16'($urandom); din2 = 16'($urandom);
      din3 = 16'($urandom); din4 = 16'($urandom);
      step(1'b1);
    end
  endtask

  initial begin
    din1 = 0; din2 = 0; din3 = 0; din4 = 0;
    cfg_valid = 0; cfg_ch = 0; cfg_gain = 0; cfg_offset = 0; sat_clr = 0;
    mdl_gain[0] = 16384; mdl_gain[1] = 16384;
    mdl_off[0]  = 0;     mdl_off[1]  = 0;

    // Reset state
    #1;
    check("rst_dout1", dout1, 0);
    check("rst_dout4", dout4, 0);
    check("rst_sat", sat, 0);
    check("rst_busy", ramp_busy, 0);
    check("rst_ready", cfg_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    check("ready_pre_clk", cfg_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check("ready_post_rst", cfg_ready, 1);

    // Unity gain pass-through, 3-clock latency
    din1 = 1000; din2 = -1000;
    step(1'b1);
    flush();
    rand_pairs(8);
    flush();
    check("sat_unity", sat, 0);

    // ch2 half gain with negative offset; rounding of +-150.5
    do_cfg(1'b1, 16'h2000, -100);
    wait_idle(3000);
    mdl_gain[1] = 16'h2000;
    din3 = 301; din4 = -301;
    step(1'b1);
    flush();
    rand_pairs(6);
    flush();

    // ch1 gain 2.0 saturates both rails
    do_cfg(1'b0, 16'h8000, 0);
    wait_idle(5000);
    mdl_gain[0] = 16'h8000;
    din1 = 20000; din2 = -20000;
    repeat (3) step(1'b1);
    check("sat_set", sat, 2'b01);
    sat_clr = 1'b1;
    step(1'b1);
    sat_clr = 1'b0;
    check("sat_set_wins", sat, 2'b01);
    din1 = 100; din2 = -100;
    repeat (3) step(1'b1);
    sat_clr = 1'b1;
    step(1'b1);
    sat_clr = 1'b0;
    check("sat_cleared", sat, 2'b00);

    // Back to 1.0, then a timed 0x4000 -> 0x4100 ramp observed via din1 = 16384
    do_cfg(1'b0, 16'h4000, 0);
    wait_idle(5000);
    mdl_gain[0] = 16'h4000;
    din1 = 16384; din2 = 0;
    repeat (3) step(1'b1);
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_gain = 16'h4100; cfg_offset = 0;
    check("ramp_ready_pre", cfg_ready, 1);
    step(1'b1);
    // Second request (same gain, offset 5) must be held off until busy falls.
    cfg_offset = 5;
    for (int i = 1; i <= 64; i++) begin
      step(1'b1);
      mdl_gain[0] = 16'h4000 + 64 * (i / 16);
      check("ramp_busy_t", ramp_busy[0], (i < 64) ? 1 : 0);
      check("ramp_ready_t", cfg_ready, (i >= 64) ? 1 : 0);
    end
    step(1'b1);
    mdl_off[0] = 5;
    cfg_valid = 1'b0;
    check("noramp_busy", ramp_busy, 0);
    check("noramp_ready", cfg_ready, 1);
    din1 = 0;
    step(1'b1);
    flush();
    check("noramp_busy_late", ramp_busy, 0);

    // Asynchronous reset in the middle of a 0x4100 -> 0x0000 ramp
    din1 = 32767;
    do_cfg(1'b0, 16'h0000, 5);
    repeat (50) step(1'b0);
    check("mid_busy", ramp_busy, 2'b01);
    check("mid_sat", sat, 2'b01);
    #2;
    rst = 1'b0;
    #1;
    check("arst_dout1", dout1, 0);
    check("arst_dout2", dout2, 0);
    check("arst_dout3", dout3, 0);
    check("arst_busy", ramp_busy, 0);
    check("arst_sat", sat, 0);
    check("arst_ready", cfg_ready, 0);
    sbq.delete();
    mdl_gain[0] = 16384; mdl_gain[1] = 16384;
    mdl_off[0]  = 0;     mdl_off[1]  = 0;
    din1 = 0;
    @(negedge clk);
    rst = 1'b1;
    check("rel_ready_pre", cfg_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check("rel_ready", cfg_ready, 1);
    din1 = 1234; din2 = -5;
    step(1'b1);
    rand_pairs(6);
    flush();
    check("rel_sat", sat, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
